// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline boundary with a two-entry skid buffer.
// The main register drives the WB-side outputs. The skid register catches
// the one extra entry that can be accepted while WB is stalled, so that
// in_ready depends only on registered state and never on out_ready.
module memwb_skid_stage #(
  parameter int DATAW  = 32,
  parameter int REGIDX = 5,
  parameter int WBSELW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATAW-1:0]  in_dmem,
  input  logic [DATAW-1:0]  in_alu,
  input  logic [DATAW-1:0]  in_pc,
  input  logic [REGIDX-1:0] in_rd,
  input  logic [WBSELW-1:0] in_wbsel,
  input  logic              in_regwrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATAW-1:0]  out_dmem,
  output logic [DATAW-1:0]  out_alu,
  output logic [DATAW-1:0]  out_pc,
  output logic [REGIDX-1:0] out_rd,
  output logic [WBSELW-1:0] out_wbsel,
  output logic              out_regwrite,
  output logic [1:0]        occupancy
);

  // Payload layout {dmem, alu, pc, rd, wbsel, regwrite}; regwrite is bit 0
  // so that flush can clear it without touching the other fields.
  localparam int PAYW = 3 * DATAW + REGIDX + WBSELW + 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic [PAYW-1:0]   r_main;
  logic [PAYW-1:0]   r_skid;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [1:0]        r_occ;

  logic [PAYW-1:0]   w_in_pay;
  logic              w_accept;
  logic              w_pop;
  logic              w_main_rw;

  assign w_in_pay = {in_dmem, in_alu, in_pc, in_rd, in_wbsel, in_regwrite};
  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = r_out_valid & out_ready;

  // Handshake state machine; flags are registered next to the state so that
  // in_ready/out_valid/occupancy come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_occ       <= 2'd0;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_main[0]   <= 1'b0;
      r_skid[0]   <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_occ       <= 2'd0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main      <= w_in_pay;
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
            r_occ       <= 2'd1;
          end
        end
        S_ONE: begin
          if (w_accept && w_pop) begin
            r_main <= w_in_pay;
          end else if (w_accept) begin
            r_skid      <= w_in_pay;
            r_state     <= S_FULL;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
            r_occ       <= 2'd2;
          end else if (w_pop) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_occ       <= 2'd0;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            r_main      <= r_skid;
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
            r_occ       <= 2'd1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_occ       <= 2'd0;
        end
      endcase
    end
  end

  assign {out_dmem, out_alu, out_pc, out_rd, out_wbsel, w_main_rw} = r_main;

  // A bubble must never write the register file.
  assign out_regwrite = w_main_rw & r_out_valid;
  assign out_valid    = r_out_valid;
  assign in_ready     = r_in_ready;
  assign occupancy    = r_occ;

endmodule
